// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: Moore sequencer for a shared ALU/memory/regfile.
// Optional memory-stall handshake compiled in with MC_CONTROLLER_STALL_EN.
module mc_controller #(
  parameter int FETCH_ONLY_RESET = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       memready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t r_state;
  state_t w_next;
  state_t w_dec;
  logic   w_ready;
  logic   w_gate;
  logic   w_pcwrite;
  logic   w_branch;
  logic   w_irwrite;
  logic   w_memwrite;
  logic   w_regwrite;
  logic   w_illegal;

`ifdef MC_CONTROLLER_STALL_EN
  assign w_ready = memready;
`else
  logic w_unused;
  assign w_unused = memready;
  assign w_ready  = 1'b1;
`endif

  // While reset is high the selects show the FETCH decode.
  assign w_dec  = reset ? S_FETCH : r_state;
  assign w_gate = (FETCH_ONLY_RESET != 0) && reset;
  assign state  = r_state;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state logic; memory states wait for memready when stalls exist.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:   w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYP:      w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   w_next = w_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_RTYPEWB;
      S_RTYPEWB: w_next = S_FETCH;
      S_BEQEX:   w_next = S_FETCH;
      S_ADDIEX:  w_next = S_ADDIWB;
      S_ADDIWB:  w_next = S_FETCH;
      S_JEX:     w_next = S_FETCH;
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore output decode of the (reset-adjusted) state.
  always_comb begin
    iord       = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_regwrite = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_illegal  = 1'b0;
    case (w_dec)
      S_FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = w_ready;
        w_pcwrite = w_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYP,
          OP_BEQ, OP_ADDI, OP_J: w_illegal = 1'b0;
          default:               w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JEX: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: begin
        iord = 1'b0;
      end
    endcase
  end

  assign irwrite  = w_irwrite  & ~w_gate;
  assign memwrite = w_memwrite & ~w_gate;
  assign regwrite = w_regwrite & ~w_gate;
  assign illegal  = w_illegal  & ~w_gate;
  assign pcen     = (w_pcwrite | (w_branch & zero)) & ~w_gate;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller.
// Stall checks are compiled in with MC_CONTROLLER_STALL_EN.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       memready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
  logic       alusrca, pcen, illegal;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .memready(memready), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  wire [12:0] w_obs = {iord, memwrite, irwrite, regdst, memtoreg,
                       regwrite, alusrca, alusrcb, aluop, pcsrc};

  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,aluop,pcsrc}
  function automatic logic [12:0] exp_outs(input logic [3:0] s);
    case (s)
      4'd0:    return 13'b0_0_1_0_0_0_0_01_00_00;
      4'd1:    return 13'b0_0_0_0_0_0_0_11_00_00;
      4'd2:    return 13'b0_0_0_0_0_0_1_10_00_00;
      4'd3:    return 13'b1_0_0_0_0_0_0_00_00_00;
      4'd4:    return 13'b0_0_0_0_1_1_0_00_00_00;
      4'd5:    return 13'b1_1_0_0_0_0_0_00_00_00;
      4'd6:    return 13'b0_0_0_0_0_0_1_00_10_00;
      4'd7:    return 13'b0_0_0_1_0_1_0_00_00_00;
      4'd8:    return 13'b0_0_0_0_0_0_1_00_01_01;
      4'd9:    return 13'b0_0_0_0_0_0_1_10_00_00;
      4'd10:   return 13'b0_0_0_0_0_1_0_00_00_00;
      4'd11:   return 13'b0_0_0_0_0_0_0_00_00_10;
      default: return 13'b0;
    endcase
  endfunction

  function automatic logic exp_pcen(input logic [3:0] s, input logic z);
    return (s == 4'd0) || (s == 4'd11) || ((s == 4'd8) && z);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go_fetch;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    memready = 1'b1;
    op = 6'b100011;
    zero = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL rst_state: got %0d want 0", state);
    end
    n_checks++;
    if ({irwrite, pcen, memwrite, regwrite} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_strobes: got ir=%b pcen=%b mw=%b rw=%b want 0",
               irwrite, pcen, memwrite, regwrite);
    end
    n_checks++;
    if (alusrcb !== 2'b01) begin
      n_fail++; $display("FAIL rst_alusrcb: got %b want 01", alusrcb);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({state, irwrite, pcen, alusrcb} !== {4'd0, 1'b1, 1'b1, 2'b01}) begin
      n_fail++;
      $display("FAIL rel_c1: got st=%0d ir=%b pcen=%b asb=%b want 0 1 1 01",
               state, irwrite, pcen, alusrcb);
    end
    tick();
    n_checks++;
    if (state !== 4'd1) begin
      n_fail++; $display("FAIL rel_c2: got %0d want 1", state);
    end
  endtask

  task automatic test_sequences(input logic z);
    logic [5:0] ops [7];
    logic [3:0] seqs [7][6];
    int         lens [7];
    ops[0] = 6'b100011; lens[0] = 6; seqs[0] = '{0, 1, 2, 3, 4, 0};
    ops[1] = 6'b101011; lens[1] = 5; seqs[1] = '{0, 1, 2, 5, 0, 0};
    ops[2] = 6'b000000; lens[2] = 5; seqs[2] = '{0, 1, 6, 7, 0, 0};
    ops[3] = 6'b001000; lens[3] = 5; seqs[3] = '{0, 1, 9, 10, 0, 0};
    ops[4] = 6'b000100; lens[4] = 4; seqs[4] = '{0, 1, 8, 0, 0, 0};
    ops[5] = 6'b000010; lens[5] = 4; seqs[5] = '{0, 1, 11, 0, 0, 0};
    ops[6] = 6'b111111; lens[6] = 3; seqs[6] = '{0, 1, 0, 0, 0, 0};
    zero = z;
    for (int k = 0; k < 7; k++) begin
      go_fetch();
      op = ops[k];
      #1;
      for (int i = 0; i < lens[k]; i++) begin
        n_checks++;
        if (state !== seqs[k][i]) begin
          n_fail++;
          $display("FAIL seq op=%b z=%b cyc%0d state: got %0d want %0d",
                   op, z, i, state, seqs[k][i]);
        end
        n_checks++;
        if (w_obs !== exp_outs(seqs[k][i])) begin
          n_fail++;
          $display("FAIL seq op=%b cyc%0d outs: got %b want %b",
                   op, i, w_obs, exp_outs(seqs[k][i]));
        end
        n_checks++;
        if (pcen !== exp_pcen(seqs[k][i], z)) begin
          n_fail++;
          $display("FAIL seq op=%b z=%b cyc%0d pcen: got %b want %b",
                   op, z, i, pcen, exp_pcen(seqs[k][i], z));
        end
        n_checks++;
        if (illegal !== (k == 6 && i == 1)) begin
          n_fail++;
          $display("FAIL seq op=%b cyc%0d illegal: got %b want %b",
                   op, i, illegal, (k == 6 && i == 1));
        end
        if (i < lens[k] - 1) tick();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_reset_mid;
    go_fetch();
    op = 6'b101011;
    tick();
    tick();
    n_checks++;
    if (state !== 4'd2) begin
      n_fail++; $display("FAIL mid_pre: got %0d want 2", state);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({memwrite, irwrite, pcen, alusrca, alusrcb} !== 5'b00001) begin
      n_fail++;
      $display("FAIL mid_rst_outs: got mw=%b ir=%b pcen=%b asa=%b asb=%b",
               memwrite, irwrite, pcen, alusrca, alusrcb);
    end
    tick();
    n_checks++;
    if (state !== 4'd0 || memwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_post: got st=%0d mw=%b want 0 0", state, memwrite);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0 || memwrite !== 1'b0 || irwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_rel: got st=%0d mw=%b ir=%b", state, memwrite, irwrite);
    end
  endtask

  task automatic test_reset_gating;
    go_fetch();
    op = 6'b100011;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (state !== 4'd4 || regwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_wb_pre: got st=%0d rw=%b want 4 1", state, regwrite);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (regwrite !== 1'b0 || memtoreg !== 1'b0) begin
      n_fail++;
      $display("FAIL gate_wb: got rw=%b mtr=%b want 0 0", regwrite, memtoreg);
    end
    go_fetch();
    op = 6'b111111;
    tick();
    n_checks++;
    if (state !== 4'd1 || illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_ill_pre: got st=%0d ill=%b want 1 1", state, illegal);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL gate_ill: got %b want 0", illegal);
    end
    tick();
    reset = 1'b0;
  endtask

`ifdef MC_CONTROLLER_STALL_EN
  task automatic test_stall;
    memready = 1'b0;
    go_fetch();
    op = 6'b101011;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({state, irwrite, pcen, alusrcb} !== {4'd0, 1'b0, 1'b0, 2'b01}) begin
        n_fail++;
        $display("FAIL stall_fetch%0d: got st=%0d ir=%b pcen=%b asb=%b",
                 i, state, irwrite, pcen, alusrcb);
      end
      tick();
    end
    memready = 1'b1;
    #1;
    n_checks++;
    if ({state, irwrite, pcen} !== {4'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_go: got st=%0d ir=%b pcen=%b", state, irwrite, pcen);
    end
    tick();
    n_checks++;
    if ({state, irwrite, pcen} !== {4'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_dec: got st=%0d ir=%b pcen=%b", state, irwrite, pcen);
    end
    tick();
    tick();
    memready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({state, memwrite, iord} !== {4'd5, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL stall_memwr%0d: got st=%0d mw=%b iord=%b",
                 i, state, memwrite, iord);
      end
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL stall_rst: got %0d want 0", state);
    end
    memready = 1'b1;
  endtask
`else
  task automatic test_memready_ignored;
    logic [3:0] exp_s [6];
    exp_s = '{0, 1, 2, 3, 4, 0};
    memready = 1'b0;
    go_fetch();
    op = 6'b100011;
    #1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (state !== exp_s[i]) begin
        n_fail++;
        $display("FAIL nostall cyc%0d: got %0d want %0d", i, state, exp_s[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (irwrite !== 1'b1 || pcen !== 1'b1) begin
          n_fail++;
          $display("FAIL nostall_fetch: got ir=%b pcen=%b want 1 1",
                   irwrite, pcen);
        end
      end
      if (i < 5) tick();
    end
    memready = 1'b1;
  endtask
`endif

  initial begin
    reset = 1'b1;
    op = 6'b0;
    zero = 1'b0;
    memready = 1'b1;
    test_reset();
    test_sequences(1'b0);
    test_sequences(1'b1);
    test_reset_mid();
    test_reset_gating();
`ifdef MC_CONTROLLER_STALL_EN
    test_stall();
`else
    test_memready_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the MIPS processor. A Moore state machine sequences a single shared ALU, memory port and register file across several cycles per instruction. It decodes opcode `op` and ALU flag `zero` into datapath enables and mux selects. It replaces the single-cycle main decoder when the datapath is built in multicycle form. It supports R-type, lw, sw, beq, addi and j.

## Interface
Parameters:
- `FETCH_ONLY_RESET`, default 1. When 1, all write strobes are forced to 0 while `reset` is high. When 0, strobes follow the FETCH decode during reset.

Ports:
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `op`  input  6  opcode field of the instruction register
- `zero`  input  1  ALU zero flag, sampled in BEQEX
- `memready`  input  1  memory access complete; used only when the stall feature is compiled in
- `iord`  output  1  memory address select: 0 = PC, 1 = ALUOut
- `memwrite`  output  1  memory write strobe
- `irwrite`  output  1  instruction register load
- `regdst`  output  1  write register select: 1 = rd, 0 = rt
- `memtoreg`  output  1  write-back source: 1 = data register, 0 = ALUOut
- `regwrite`  output  1  register file write
- `alusrca`  output  1  ALU A select: 0 = PC, 1 = register A
- `alusrcb`  output  2  ALU B select: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2
- `aluop`  output  2  00 = add, 01 = sub, 10 = funct-decoded
- `pcsrc`  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `pcen`  output  1  PC write enable, computed as pcwrite | (branch & zero)
- `illegal`  output  1  one-cycle pulse when DECODE sees an unsupported opcode
- `state`  output  4  current state encoding, for debug

## Operation
State encodings:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
- RTYPEEX = 6, RTYPEWB = 7, BEQEX = 8, ADDIEX = 9, ADDIWB = 10, JEX = 11
- Encodings 12–15 are unreachable; if entered, the next state is FETCH.

Transitions and asserted outputs (any output not listed is 0):
- FETCH: iord=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1. Next state is DECODE.
- DECODE: alusrcb=11, aluop=00 (computes the branch target). Next state depends on `op`:
  - 100011 or 101011 → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 001000 → ADDIEX
  - 000010 → JEX
  - any other value → FETCH, with `illegal`=1
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next is MEMRD if op=100011, otherwise MEMWR.
- MEMRD: iord=1. Next is MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next is FETCH.
- MEMWR: iord=1, memwrite=1. Next is FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Next is RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next is FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next is FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next is ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next is FETCH.
- JEX: pcsrc=10, pcwrite=1. Next is FETCH.

Output and reset rules:
- `pcwrite` and `branch` are internal signals; only `pcen` leaves the block.
- All outputs are combinational from `state` (plus `zero` for `pcen`, and `memready` when the stall feature is enabled).
- Reset forces `state` to FETCH at the next edge, from any state; this includes a partially executed instruction.
- While `reset` is high with `FETCH_ONLY_RESET`=1: irwrite, pcen, memwrite, regwrite and illegal are 0. The select outputs show FETCH values.

## Timing
- State register updates on rising `clk` only.
- First FETCH after reset release: `state` is 0 in the first cycle with `reset` low.
- Cycles per instruction without stalls:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2
- `op` must be stable during DECODE and MEMADR; the IR is not written outside FETCH.
- `zero` is sampled combinationally in BEQEX only. A `zero` glitch in any other state has no effect on `pcen`.

## Configuration
- `MC_CONTROLLER_STALL_EN` defined: FETCH, MEMRD and MEMWR hold their state while `memready`=0.
  - Select outputs and memwrite stay asserted during the hold.
  - irwrite and pcen in FETCH are asserted only in the cycle where `memready`=1.
  - Reset during a hold still returns the machine to FETCH.
- Undefined: `memready` is ignored, and every state lasts exactly one cycle.

## Test plan
- Reset for 2 cycles, then release:
  - During reset: state=0, irwrite=0, pcen=0.
  - After release, cycle 1: irwrite=1, pcen=1, alusrcb=01.
  - Cycle 2: state=1.
- op=100011 (lw): state sequence 0,1,2,3,4,0. In the state-4 cycle, regwrite=1, memtoreg=1, regdst=0.
- op=000100 (beq):
  - zero=1: state sequence 0,1,8,0, with pcen=1 and pcsrc=01 in state 8.
  - Repeat with zero=0: pcen=0 in state 8.
- op=111111: state sequence 0,1,0. `illegal`=1 only in the state-1 cycle; regwrite and memwrite are never asserted.
- Reset mid-instruction: op=101011, assert reset in state 2, so MEMWR is never entered.
  - Next state is 0.
  - memwrite is never 1.
- With `MC_CONTROLLER_STALL_EN`:
  - Hold memready=0 for 3 cycles in FETCH: state stays 0, and irwrite/pcen stay 0.
  - memready=1: irwrite=1 and pcen=1 for exactly one cycle, then state=1.
